// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions.
//  - LD_*      : RV32 load funct3 encodings understood by the load formatter
//  - wb_src_e  : canonical writeback source indices for the 4-source pipeline
//  - sext()    : sign-extend a value whose sign bit sits at position msb;
//                also used by the decode stage for immediates (msb = 11, 12, 20 ...)
package wb_pkg;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_src_e;

    // Bits above msb are replaced by copies of v[msb]; bits at and below msb pass.
    function automatic logic [63:0] sext(input logic [63:0] v, input logic [5:0] msb);
        logic [63:0] upper;
        upper = {64{1'b1}} << msb;
        upper = upper << 1;
        return v[msb] ? (v | upper) : (v & ~upper);
    endfunction

endpackage

// File: rtl/wb_stage_reg_if.sv
// Bus bundle between the MEM stage and the registered writeback stage.
//  slave  modport : used by wb_stage_reg (consumes *_i, drives *_o)
//  master modport : used by the upstream pipeline / testbench
//
// Handshake: valid_i qualifies every other *_i field in the cycle it is high.
// There is no ready signal; stall_i is the only backpressure, and while it is
// high nothing is captured, so upstream must keep presenting the same
// instruction until stall_i drops. flush_i discards whatever is presented.
interface wb_stage_reg_if #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 4,
    parameter int RADDR_W = 5
);
    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic                    stall_i;
    logic                    flush_i;
    logic                    valid_i;
    logic [SEL_W-1:0]        wb_sel_i;
    logic [NSRC*WIDTH-1:0]   src_i;
    logic                    reg_wr_i;
    logic [RADDR_W-1:0]      rd_i;
    logic [2:0]              ld_fmt_i;
    logic [1:0]              byte_off_i;

    logic                    valid_o;
    logic                    rf_we_o;
    logic [RADDR_W-1:0]      rf_waddr_o;
    logic [WIDTH-1:0]        rf_wdata_o;
    logic                    sel_err_o;

    modport slave (
        input  stall_i, flush_i, valid_i, wb_sel_i, src_i, reg_wr_i, rd_i,
               ld_fmt_i, byte_off_i,
        output valid_o, rf_we_o, rf_waddr_o, rf_wdata_o, sel_err_o
    );

    modport master (
        output stall_i, flush_i, valid_i, wb_sel_i, src_i, reg_wr_i, rd_i,
               ld_fmt_i, byte_off_i,
        input  valid_o, rf_we_o, rf_waddr_o, rf_wdata_o, sel_err_o
    );

endinterface

// File: rtl/load_fmt.sv
// Combinational RV32 load formatter.
//  raw  : raw memory read word (only raw[31:0] is meaningful)
//  fmt  : load funct3
//  off  : address[1:0] of the load, selects the byte / halfword lane
//  data : lane-aligned, sign- or zero-extended result, WIDTH bits
module load_fmt
    import wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] raw,
    input  logic [2:0]       fmt,
    input  logic [1:0]       off,
    output logic [WIDTH-1:0] data
);

    logic [31:0] word;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        word = raw[31:0];

        case (off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase

        // off[0] is deliberately ignored: misaligned halfwords trap upstream.
        lane_h = off[1] ? word[31:16] : word[15:0];

        case (fmt)
            LD_B:    data = WIDTH'(sext({56'd0, lane_b}, 6'd7));
            LD_BU:   data = WIDTH'({56'd0, lane_b});
            LD_H:    data = WIDTH'(sext({48'd0, lane_h}, 6'd15));
            LD_HU:   data = WIDTH'({48'd0, lane_h});
            // On a 64-bit datapath LW sign-extends; on 32 bits this is a plain copy.
            LD_W:    data = WIDTH'(sext({32'd0, word}, 6'd31));
            default: data = WIDTH'({32'd0, word});
        endcase
    end

endmodule

// File: rtl/wb_stage_reg.sv
// Registered writeback stage (MEM/WB boundary) of the RV32 pipeline.
//  clk, rst : rising-edge clock, synchronous active-high reset
//  wb       : wb_stage_reg_if.slave
//     in : stall_i flush_i valid_i wb_sel_i src_i reg_wr_i rd_i ld_fmt_i byte_off_i
//     out: valid_o rf_we_o rf_waddr_o rf_wdata_o sel_err_o (all registered)
// Picks one of NSRC packed sources, formats it when it is the memory source,
// and registers the register-file write port. Edge priority:
// rst > flush_i > stall_i > load. Outputs also feed WB->EX forwarding.
module wb_stage_reg
    import wb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 4,
    parameter int LOAD_SEL = int'(WB_MEM),
    parameter int RADDR_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_stage_reg_if.slave        wb
);

    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int SW1   = SEL_W + 1;
    // One extra bit so that NSRC itself (e.g. 4 with a 2-bit select) is representable.
    localparam logic [SEL_W:0] NSRC_L = SW1'(NSRC);
    localparam logic [SEL_W:0] LOAD_L = SW1'(LOAD_SEL);

    logic [WIDTH-1:0] raw_sel;
    logic [WIDTH-1:0] fmt_data;
    logic [WIDTH-1:0] wdata_d;
    logic             sel_ok;
    logic             is_load;
    logic             we_d;
    logic             err_d;

    always_comb begin
        raw_sel = '0;
        for (int k = 0; k < NSRC; k++) begin
            if ({1'b0, wb.wb_sel_i} == SW1'(k)) begin
                raw_sel = wb.src_i[k*WIDTH +: WIDTH];
            end
        end

        sel_ok  = {1'b0, wb.wb_sel_i} < NSRC_L;
        is_load = {1'b0, wb.wb_sel_i} == LOAD_L;

        // An out-of-range select writes zero and never enables the register file.
        if (!sel_ok) begin
            wdata_d = '0;
        end else if (is_load) begin
            wdata_d = fmt_data;
        end else begin
            wdata_d = raw_sel;
        end

        // x0 writes are dropped here but the instruction itself stays valid.
        we_d  = wb.valid_i & wb.reg_wr_i & (wb.rd_i != '0) & sel_ok;
        err_d = wb.valid_i & ~sel_ok;
    end

    load_fmt #(
        .WIDTH (WIDTH)
    ) u_load_fmt (
        .raw  (raw_sel),
        .fmt  (wb.ld_fmt_i),
        .off  (wb.byte_off_i),
        .data (fmt_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb.valid_o    <= 1'b0;
            wb.rf_we_o    <= 1'b0;
            wb.sel_err_o  <= 1'b0;
            wb.rf_waddr_o <= '0;
            wb.rf_wdata_o <= '0;
        end else if (wb.flush_i) begin
            // Address/data are left alone: with rf_we_o low they are don't-care.
            wb.valid_o    <= 1'b0;
            wb.rf_we_o    <= 1'b0;
            wb.sel_err_o  <= 1'b0;
        end else if (!wb.stall_i) begin
            wb.valid_o    <= wb.valid_i;
            wb.rf_we_o    <= we_d;
            wb.sel_err_o  <= err_d;
            wb.rf_waddr_o <= wb.rd_i;
            wb.rf_wdata_o <= wdata_d;
        end
    end

endmodule
